// File: rtl/cmp_result_monitor_pkg.sv
// Shared encodings for cmp_result_monitor: lock FSM states and comparator flag triples.
package cmp_result_monitor_pkg;

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] TRACK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  // Flag triples ordered {A_greater, A_equal, A_less}
  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  function automatic logic is_one_hot3(input logic [2:0] f);
    return (f == GT) || (f == EQ) || (f == LT);
  endfunction

endpackage

// File: rtl/cmp_event_counter.sv
// Event counter with synchronous clear; wraps by default, saturates when
// CMP_RESULT_MONITOR_SAT_EN is defined.
module cmp_event_counter #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_count;

  // Count accepted events; clear has priority
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
`ifdef CMP_RESULT_MONITOR_SAT_EN
      if (r_count != MAX) begin
        r_count <= r_count + ONE;
      end
`else
      r_count <= r_count + ONE;
`endif
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cmp_result_monitor.sv
// Consumer of comparator flag triples: per-outcome counters, equal-run lock FSM
// and malformed-triple error pulse. Optional macro: CMP_RESULT_MONITOR_SAT_EN.
import cmp_result_monitor_pkg::*;

module cmp_result_monitor #(
  parameter int CNT_W    = 8,
  parameter int LOCK_LEN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             A_greater,
  input  logic             A_equal,
  input  logic             A_less,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] lt_count,
  output logic             lock,
  output logic             err
);

  localparam logic [3:0] LOCK_LEN_4 = LOCK_LEN[3:0];

  logic [2:0] w_flags;
  logic       w_accept;
  logic       w_valid_triple;
  logic       w_clr;
  logic [1:0] w_state_nxt;
  logic [3:0] w_run_nxt;
  logic [1:0] r_state;
  logic [3:0] r_run;
  logic       r_lock;
  logic       r_err;

  assign in_ready       = ~clear & ~rst;
  assign w_flags        = {A_greater, A_equal, A_less};
  assign w_accept       = in_valid & in_ready;
  assign w_valid_triple = is_one_hot3(w_flags);
  assign w_clr          = rst | clear;

  cmp_event_counter #(.CNT_W(CNT_W)) u_gt_cnt (
    .i_clk   (clk),
    .i_clr   (w_clr),
    .i_inc   (w_accept & (w_flags == GT)),
    .o_count (gt_count)
  );

  cmp_event_counter #(.CNT_W(CNT_W)) u_eq_cnt (
    .i_clk   (clk),
    .i_clr   (w_clr),
    .i_inc   (w_accept & (w_flags == EQ)),
    .o_count (eq_count)
  );

  cmp_event_counter #(.CNT_W(CNT_W)) u_lt_cnt (
    .i_clk   (clk),
    .i_clr   (w_clr),
    .i_inc   (w_accept & (w_flags == LT)),
    .o_count (lt_count)
  );

  // Lock FSM next state: any accepted non-equal or malformed triple restarts the search
  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    if (w_accept) begin
      if (w_flags == EQ) begin
        case (r_state)
          SEARCH: begin
            w_run_nxt   = 4'd1;
            w_state_nxt = (LOCK_LEN_4 == 4'd1) ? LOCKED : TRACK;
          end
          TRACK: begin
            w_run_nxt   = r_run + 4'd1;
            w_state_nxt = ((r_run + 4'd1) == LOCK_LEN_4) ? LOCKED : TRACK;
          end
          LOCKED: begin
            w_run_nxt   = LOCK_LEN_4;
            w_state_nxt = LOCKED;
          end
          default: begin
            w_run_nxt   = 4'd0;
            w_state_nxt = SEARCH;
          end
        endcase
      end else begin
        w_run_nxt   = 4'd0;
        w_state_nxt = SEARCH;
      end
    end else begin
      w_run_nxt   = r_run;
      w_state_nxt = r_state;
    end
  end

  // State, lock and error registers; clear behaves exactly like reset
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state <= SEARCH;
      r_run   <= 4'd0;
      r_lock  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
      r_lock  <= (w_state_nxt == LOCKED);
      r_err   <= w_accept & ~w_valid_triple;
    end
  end

  assign lock = r_lock;
  assign err  = r_err;

endmodule

// File: tb/tb_cmp_result_monitor.sv
// Randomized + directed self-checking bench for cmp_result_monitor against a
// totals/streak reference model.
module tb_cmp_result_monitor;
  import cmp_result_monitor_pkg::*;

  localparam int CNT_W    = 4;
  localparam int LOCK_LEN = 3;
  localparam int MAXV     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic A_greater = 1'b0;
  logic A_equal = 1'b0;
  logic A_less = 1'b0;
  logic in_ready;
  logic [CNT_W-1:0] gt_count, eq_count, lt_count;
  logic lock, err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: unbounded totals and current run of equals
  int tot_gt = 0, tot_eq = 0, tot_lt = 0, streak = 0;
  bit exp_err = 1'b0;

  always #5 clk = ~clk;

  cmp_result_monitor #(.CNT_W(CNT_W), .LOCK_LEN(LOCK_LEN)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .A_greater(A_greater), .A_equal(A_equal), .A_less(A_less),
    .gt_count(gt_count), .eq_count(eq_count), .lt_count(lt_count),
    .lock(lock), .err(err)
  );

  function automatic int exp_cnt(input int t);
`ifdef CMP_RESULT_MONITOR_SAT_EN
    return (t > MAXV) ? MAXV : t;
`else
    return t % (MAXV + 1);
`endif
  endfunction

  function automatic logic [2:0] cmp_flags(input int a, input int b);
    if (a > b) return GT;
    else if (a == b) return EQ;
    else return LT;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic c, input logic v, input logic [2:0] f);
    if (r || c) begin
      tot_gt = 0; tot_eq = 0; tot_lt = 0; streak = 0; exp_err = 1'b0;
    end else if (v) begin
      exp_err = 1'b0;
      if ($countones(f) != 1) begin
        exp_err = 1'b1; streak = 0;
      end else if (f == GT) begin
        tot_gt++; streak = 0;
      end else if (f == EQ) begin
        tot_eq++; streak++;
      end else begin
        tot_lt++; streak = 0;
      end
    end else begin
      exp_err = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then advance the model
  task automatic step(input logic r, input logic c, input logic v, input logic [2:0] f);
    rst = r; clear = c; in_valid = v;
    {A_greater, A_equal, A_less} = f;
    @(posedge clk);
    model_update(r, c, v, f);
    #1;
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("gt_count", int'(gt_count), exp_cnt(tot_gt));
      cmp("eq_count", int'(eq_count), exp_cnt(tot_eq));
      cmp("lt_count", int'(lt_count), exp_cnt(tot_lt));
      cmp("lock", int'(lock), (streak >= LOCK_LEN) ? 1 : 0);
      cmp("err", int'(err), int'(exp_err));
      cmp("in_ready", int'(in_ready), (!clear && !rst) ? 1 : 0);
    end
  end

  initial begin
    // Reset with in_valid high
    step(1'b1, 1'b0, 1'b1, EQ);
    chk_en = 1'b1;
    step(1'b1, 1'b0, 1'b1, EQ);
    cmp("rst_in_ready", int'(in_ready), 0);
    cmp("rst_gt", int'(gt_count), 0);
    cmp("rst_eq", int'(eq_count), 0);
    cmp("rst_lock", int'(lock), 0);
    cmp("rst_err", int'(err), 0);

    // Mixed stream: 4<7, 8>3, 5==5, 0<15, 15>0
    step(1'b0, 1'b0, 1'b1, cmp_flags(4, 7));
    step(1'b0, 1'b0, 1'b1, cmp_flags(8, 3));
    step(1'b0, 1'b0, 1'b1, cmp_flags(5, 5));
    step(1'b0, 1'b0, 1'b1, cmp_flags(0, 15));
    step(1'b0, 1'b0, 1'b1, cmp_flags(15, 0));
    cmp("mix_gt", int'(gt_count), 2);
    cmp("mix_eq", int'(eq_count), 1);
    cmp("mix_lt", int'(lt_count), 2);
    cmp("mix_lock", int'(lock), 0);

    // Lock after three equals, released by a less
    step(1'b0, 1'b0, 1'b1, EQ);
    step(1'b0, 1'b0, 1'b1, EQ);
    cmp("lock_after2", int'(lock), 0);
    step(1'b0, 1'b0, 1'b1, EQ);
    cmp("lock_after3", int'(lock), 1);
    step(1'b0, 1'b0, 1'b0, EQ);
    cmp("lock_idle_hold", int'(lock), 1);
    step(1'b0, 1'b0, 1'b1, LT);
    cmp("lock_release", int'(lock), 0);
    cmp("lock_lt", int'(lt_count), 3);

    // Errors from TRACK with run=2
    step(1'b0, 1'b0, 1'b1, EQ);
    step(1'b0, 1'b0, 1'b1, EQ);
    step(1'b0, 1'b0, 1'b1, 3'b110);
    cmp("err_110", int'(err), 1);
    step(1'b0, 1'b0, 1'b1, 3'b000);
    cmp("err_000", int'(err), 1);
    cmp("err_eq_unchanged", int'(eq_count), 6);
    step(1'b0, 1'b0, 1'b0, 3'b000);
    cmp("err_drop", int'(err), 0);
    step(1'b0, 1'b0, 1'b1, EQ);
    step(1'b0, 1'b0, 1'b1, EQ);
    cmp("err_research", int'(lock), 0);
    step(1'b0, 1'b0, 1'b1, EQ);
    cmp("err_relock", int'(lock), 1);

    // Clear with a valid triple presented
    step(1'b0, 1'b0, 1'b1, GT);
    step(1'b0, 1'b0, 1'b1, GT);
    step(1'b0, 1'b0, 1'b1, GT);
    cmp("clr_gt5", int'(gt_count), 5);
    rst = 1'b0; clear = 1'b1; in_valid = 1'b1; {A_greater, A_equal, A_less} = GT;
    #1;
    cmp("clr_in_ready", int'(in_ready), 0);
    step(1'b0, 1'b1, 1'b1, GT);
    cmp("clr_gt", int'(gt_count), 0);
    cmp("clr_eq", int'(eq_count), 0);
    cmp("clr_lock", int'(lock), 0);

    // Overflow: 17 greaters
    for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 1'b1, GT);
`ifdef CMP_RESULT_MONITOR_SAT_EN
    cmp("ovf_gt", int'(gt_count), 15);
`else
    cmp("ovf_gt", int'(gt_count), 1);
`endif

    // Randomized stream
    for (int i = 0; i < 3000; i++) begin
      int sel;
      logic [2:0] f;
      logic r, c, v;
      sel = $urandom_range(0, 9);
      if (sel < 4) f = EQ;
      else if (sel < 6) f = GT;
      else if (sel < 8) f = LT;
      else f = 3'($urandom_range(0, 7));
      r = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 9) < 7);
      step(r, c, v, f);
    end
    step(1'b0, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
